// File: rtl/qspim_req_arb.sv
// qspim_req_arb: two-master arbiter in front of qspim_if's single Wishbone burst port.
// Grant is held for a whole burst; a one-cycle GAP forces s_stb_o low between grants.
module qspim_req_arb #(
    parameter int unsigned WB_WIDTH = 32,
    parameter int unsigned TMO_W    = 16
) (
    input  logic                mclk,
    input  logic                rst_n,

    input  logic                m0_stb_i,
    input  logic [WB_WIDTH-1:0] m0_adr_i,
    input  logic                m0_we_i,
    input  logic [WB_WIDTH-1:0] m0_dat_i,
    input  logic [3:0]          m0_sel_i,
    input  logic [9:0]          m0_bl_i,
    input  logic                m0_bry_i,
    output logic [WB_WIDTH-1:0] m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_lack_o,
    output logic                m0_err_o,

    input  logic                m1_stb_i,
    input  logic [WB_WIDTH-1:0] m1_adr_i,
    input  logic                m1_we_i,
    input  logic [WB_WIDTH-1:0] m1_dat_i,
    input  logic [3:0]          m1_sel_i,
    input  logic [9:0]          m1_bl_i,
    input  logic                m1_bry_i,
    output logic [WB_WIDTH-1:0] m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_lack_o,
    output logic                m1_err_o,

    output logic                s_stb_o,
    output logic [WB_WIDTH-1:0] s_adr_o,
    output logic                s_we_o,
    output logic [WB_WIDTH-1:0] s_dat_o,
    output logic [3:0]          s_sel_o,
    output logic [9:0]          s_bl_o,
    output logic                s_bry_o,
    input  logic [WB_WIDTH-1:0] s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_lack_i,
    input  logic                s_err_i,

    input  logic                cfg_arb_mode,
    input  logic [TMO_W-1:0]    cfg_tmo,
    input  logic                cfg_fsm_reset,
    output logic [1:0]          arb_gnt,
    output logic [1:0]          arb_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_GAP  = 2'b10
    } state_e;

    localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               last_q, last_d;     // 1 = M1 held the last completed grant
    logic [TMO_W-1:0]   wdog_q, wdog_d;

    logic               busy;
    logic               gstb;
    logic               expire;
    logic               wdog_err;
    logic               g0, g1;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= 1'b1;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        busy   = (state_q == ST_BUSY);
        gstb   = gnt_q[1] ? m1_stb_i : m0_stb_i;
        expire = (cfg_tmo != '0) && (wdog_q == (cfg_tmo - TMO_ONE)) && !s_ack_i;
        g0     = busy & gnt_q[0];
        g1     = busy & gnt_q[1];
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        wdog_d   = wdog_q;
        wdog_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_stb_i || m1_stb_i) begin
                    state_d = ST_BUSY;
                    wdog_d  = '0;
                    if (m0_stb_i && m1_stb_i)
                        gnt_d = (cfg_arb_mode || last_q) ? 2'b01 : 2'b10;
                    else
                        gnt_d = m0_stb_i ? 2'b01 : 2'b10;
                end
            end
            ST_BUSY: begin
                if (s_ack_i)
                    wdog_d = '0;
                else if (wdog_q != '1)
                    wdog_d = wdog_q + TMO_ONE;

                // Exit priority: last-ack, then abort, then watchdog.
                if (s_lack_i) begin
                    last_d  = gnt_q[1];
                    state_d = ST_GAP;
                    gnt_d   = '0;
                end else if (!gstb) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                end else if (expire) begin
                    wdog_err = 1'b1;
                    state_d  = ST_GAP;
                    gnt_d    = '0;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        if (cfg_fsm_reset) begin
            state_d  = ST_IDLE;
            gnt_d    = '0;
            wdog_d   = '0;
            last_d   = last_q;
            wdog_err = 1'b0;
        end
    end

    always_comb begin
        s_stb_o = 1'b0;
        s_adr_o = '0;
        s_we_o  = 1'b0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_bl_o  = '0;
        s_bry_o = 1'b0;
        if (busy) begin
            s_stb_o = gstb;
            s_adr_o = gnt_q[1] ? m1_adr_i : m0_adr_i;
            s_we_o  = gnt_q[1] ? m1_we_i  : m0_we_i;
            s_dat_o = gnt_q[1] ? m1_dat_i : m0_dat_i;
            s_sel_o = gnt_q[1] ? m1_sel_i : m0_sel_i;
            s_bl_o  = gnt_q[1] ? m1_bl_i  : m0_bl_i;
            s_bry_o = gnt_q[1] ? m1_bry_i : m0_bry_i;
        end

        m0_dat_o  = g0 ? s_dat_i : '0;
        m0_ack_o  = g0 & s_ack_i;
        m0_lack_o = g0 & s_lack_i;
        m0_err_o  = g0 & (s_err_i | wdog_err);
        m1_dat_o  = g1 ? s_dat_i : '0;
        m1_ack_o  = g1 & s_ack_i;
        m1_lack_o = g1 & s_lack_i;
        m1_err_o  = g1 & (s_err_i | wdog_err);

        arb_gnt   = gnt_q;
        arb_state = state_q;
    end

endmodule

// File: tb/tb_qspim_req_arb.sv
// Directed self-checking bench for qspim_req_arb: inputs driven 2ns after posedge,
// outputs checked 1ns later.
module tb_qspim_req_arb;

    logic        mclk, rst_n;
    logic        m0_stb_i, m0_we_i, m0_bry_i, m1_stb_i, m1_we_i, m1_bry_i;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic [9:0]  m0_bl_i, m1_bl_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_lack_o, m0_err_o, m1_ack_o, m1_lack_o, m1_err_o;
    logic        s_stb_o, s_we_o, s_bry_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic [9:0]  s_bl_o;
    logic        s_ack_i, s_lack_i, s_err_i;
    logic        cfg_arb_mode, cfg_fsm_reset;
    logic [15:0] cfg_tmo;
    logic [1:0]  arb_gnt, arb_state;

    int nchk = 0;
    int nerr = 0;

    qspim_req_arb #(.WB_WIDTH(32), .TMO_W(16)) dut (
        .mclk(mclk), .rst_n(rst_n),
        .m0_stb_i(m0_stb_i), .m0_adr_i(m0_adr_i), .m0_we_i(m0_we_i), .m0_dat_i(m0_dat_i),
        .m0_sel_i(m0_sel_i), .m0_bl_i(m0_bl_i), .m0_bry_i(m0_bry_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_lack_o(m0_lack_o), .m0_err_o(m0_err_o),
        .m1_stb_i(m1_stb_i), .m1_adr_i(m1_adr_i), .m1_we_i(m1_we_i), .m1_dat_i(m1_dat_i),
        .m1_sel_i(m1_sel_i), .m1_bl_i(m1_bl_i), .m1_bry_i(m1_bry_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_lack_o(m1_lack_o), .m1_err_o(m1_err_o),
        .s_stb_o(s_stb_o), .s_adr_o(s_adr_o), .s_we_o(s_we_o), .s_dat_o(s_dat_o),
        .s_sel_o(s_sel_o), .s_bl_o(s_bl_o), .s_bry_o(s_bry_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_lack_i(s_lack_i), .s_err_i(s_err_i),
        .cfg_arb_mode(cfg_arb_mode), .cfg_tmo(cfg_tmo), .cfg_fsm_reset(cfg_fsm_reset),
        .arb_gnt(arb_gnt), .arb_state(arb_state)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge mclk);
        #2;
    endtask

    task automatic clear_inputs();
        m0_stb_i = 0; m0_adr_i = '0; m0_we_i = 0; m0_dat_i = '0; m0_sel_i = 4'hF; m0_bl_i = '0; m0_bry_i = 0;
        m1_stb_i = 0; m1_adr_i = '0; m1_we_i = 0; m1_dat_i = '0; m1_sel_i = 4'hF; m1_bl_i = '0; m1_bry_i = 0;
        s_dat_i = '0; s_ack_i = 0; s_lack_i = 0; s_err_i = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; cfg_fsm_reset = 0;
        clear_inputs();
        repeat (2) @(posedge mclk);
        #2 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; cfg_fsm_reset = 0; cfg_arb_mode = 0; cfg_tmo = '0;
        clear_inputs();
        m0_stb_i = 1;
        repeat (3) @(posedge mclk);
        #3;
        nchk++; if (arb_state !== 2'b00) begin nerr++; $display("FAIL rst_state: got %b want 00", arb_state); end
        nchk++; if (arb_gnt !== 2'b00) begin nerr++; $display("FAIL rst_gnt: got %b want 00", arb_gnt); end
        nchk++; if (s_stb_o !== 1'b0) begin nerr++; $display("FAIL rst_stb: got %b want 0", s_stb_o); end
        nchk++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0) begin nerr++; $display("FAIL rst_mout: got %b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
        m0_stb_i = 0;
        #2 rst_n = 1;
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        m0_stb_i = 1; m0_adr_i = 32'h0000_0100; m0_bl_i = 10'd1; m0_sel_i = 4'hF;
        #1;
        nchk++; if (s_stb_o !== 1'b0 || arb_state !== 2'b00) begin nerr++; $display("FAIL t1_idle: got stb=%b st=%b want 0/00", s_stb_o, arb_state); end
        tick(); #1;
        nchk++; if (arb_gnt !== 2'b01) begin nerr++; $display("FAIL t1_gnt: got %b want 01", arb_gnt); end
        nchk++; if (arb_state !== 2'b01) begin nerr++; $display("FAIL t1_state_busy: got %b want 01", arb_state); end
        nchk++; if (s_stb_o !== 1'b1 || s_adr_o !== 32'h100 || s_bl_o !== 10'd1) begin nerr++; $display("FAIL t1_mux: got stb=%b adr=%h bl=%0d want 1/100/1", s_stb_o, s_adr_o, s_bl_o); end
        tick(); tick(); tick();
        s_ack_i = 1; s_lack_i = 1; s_dat_i = 32'hCAFE_F00D;
        #1;
        nchk++; if (m0_ack_o !== 1'b1 || m0_lack_o !== 1'b1) begin nerr++; $display("FAIL t1_ack: got ack=%b lack=%b want 1/1", m0_ack_o, m0_lack_o); end
        nchk++; if (m0_dat_o !== 32'hCAFE_F00D) begin nerr++; $display("FAIL t1_dat: got %h want cafef00d", m0_dat_o); end
        nchk++; if (m1_ack_o !== 1'b0 || m1_lack_o !== 1'b0 || m1_dat_o !== 32'h0) begin nerr++; $display("FAIL t1_m1_quiet: got ack=%b lack=%b dat=%h want 0", m1_ack_o, m1_lack_o, m1_dat_o); end
        tick();
        m0_stb_i = 0; s_lack_i = 0; s_ack_i = 1;
        #1;
        nchk++; if (arb_state !== 2'b10 || arb_gnt !== 2'b00 || s_stb_o !== 1'b0) begin nerr++; $display("FAIL t1_gap: got st=%b gnt=%b stb=%b want 10/00/0", arb_state, arb_gnt, s_stb_o); end
        nchk++; if (m0_ack_o !== 1'b0) begin nerr++; $display("FAIL t1_stray_ack: got %b want 0", m0_ack_o); end
        tick();
        s_ack_i = 0;
        #1;
        nchk++; if (arb_state !== 2'b00) begin nerr++; $display("FAIL t1_idle_after: got %b want 00", arb_state); end
    endtask

    task automatic test_round_robin();
        do_reset();
        cfg_arb_mode = 0;
        m0_stb_i = 1; m0_adr_i = 32'h200; m0_bl_i = 10'd2;
        m1_stb_i = 1; m1_adr_i = 32'h300; m1_bl_i = 10'd2;
        tick(); #1;
        nchk++; if (arb_gnt !== 2'b01 || s_adr_o !== 32'h200) begin nerr++; $display("FAIL t2_first_m0: got gnt=%b adr=%h want 01/200", arb_gnt, s_adr_o); end
        s_ack_i = 1; s_dat_i = 32'h1;
        #1;
        nchk++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin nerr++; $display("FAIL t2_m0_beat: got m0=%b m1=%b want 1/0", m0_ack_o, m1_ack_o); end
        tick();
        s_lack_i = 1;
        tick();
        s_ack_i = 0; s_lack_i = 0;
        #1;
        nchk++; if (arb_state !== 2'b10 || s_stb_o !== 1'b0) begin nerr++; $display("FAIL t2_gap: got st=%b stb=%b want 10/0", arb_state, s_stb_o); end
        tick(); #1;
        nchk++; if (arb_state !== 2'b00 || arb_gnt !== 2'b00) begin nerr++; $display("FAIL t2_idle: got st=%b gnt=%b want 00/00", arb_state, arb_gnt); end
        tick(); #1;
        nchk++; if (arb_gnt !== 2'b10 || s_adr_o !== 32'h300) begin nerr++; $display("FAIL t2_then_m1: got gnt=%b adr=%h want 10/300", arb_gnt, s_adr_o); end
        s_ack_i = 1;
        #1;
        nchk++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin nerr++; $display("FAIL t2_m1_beat: got m1=%b m0=%b want 1/0", m1_ack_o, m0_ack_o); end
        tick();
        s_lack_i = 1;
        tick();
        s_ack_i = 0; s_lack_i = 0;
        tick(); tick(); #1;
        nchk++; if (arb_gnt !== 2'b01) begin nerr++; $display("FAIL t2_tie_m0_again: got %b want 01", arb_gnt); end
        s_ack_i = 1; s_lack_i = 1;
        tick();
        s_ack_i = 0; s_lack_i = 0; m0_stb_i = 0; m1_stb_i = 0;
        tick();
    endtask

    task automatic test_fixed_priority();
        logic [31:0] wd;
        cfg_arb_mode = 1;
        m1_stb_i = 1; m1_we_i = 1; m1_bl_i = 10'd4; m1_adr_i = 32'h400; m1_dat_i = 32'h1111_0000;
        tick(); #1;
        nchk++; if (arb_gnt !== 2'b10 || s_we_o !== 1'b1 || s_bl_o !== 10'd4) begin nerr++; $display("FAIL t3_m1_gnt: got gnt=%b we=%b bl=%0d want 10/1/4", arb_gnt, s_we_o, s_bl_o); end
        for (int b = 1; b <= 4; b++) begin
            if (b > 1) tick();
            wd = 32'h1111_0000 + b;
            m1_dat_i = wd; s_ack_i = 1; s_lack_i = (b == 4);
            if (b == 2) m0_stb_i = 1;
            #1;
            nchk++; if (s_dat_o !== wd || arb_gnt !== 2'b10 || m1_ack_o !== 1'b1) begin nerr++; $display("FAIL t3_beat%0d: got dat=%h gnt=%b ack=%b want %h/10/1", b, s_dat_o, arb_gnt, m1_ack_o, wd); end
        end
        nchk++; if (m1_lack_o !== 1'b1) begin nerr++; $display("FAIL t3_lack: got %b want 1", m1_lack_o); end
        tick();
        s_ack_i = 0; s_lack_i = 0; m1_stb_i = 0; m1_we_i = 0;
        tick(); tick(); #1;
        nchk++; if (arb_gnt !== 2'b01) begin nerr++; $display("FAIL t3_m0_next: got %b want 01", arb_gnt); end
        s_ack_i = 1; s_lack_i = 1;
        tick();
        s_ack_i = 0; s_lack_i = 0; m1_stb_i = 1;
        tick(); tick(); #1;
        nchk++; if (arb_gnt !== 2'b01) begin nerr++; $display("FAIL t3_tie_fixed: got %b want 01", arb_gnt); end
        s_ack_i = 1; s_lack_i = 1;
        tick();
        s_ack_i = 0; s_lack_i = 0; m0_stb_i = 0; m1_stb_i = 0;
        tick();
        cfg_arb_mode = 0;
    endtask

    task automatic test_watchdog();
        int errs;
        do_reset();
        cfg_tmo = 16'd8;
        m0_stb_i = 1; m0_adr_i = 32'h500;
        tick();
        m1_stb_i = 1; m1_adr_i = 32'h600;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc > 1) tick();
            #1;
            nchk++; if (m0_err_o !== (cyc == 8) || s_stb_o !== 1'b1) begin nerr++; $display("FAIL t4_wdog_c%0d: got err=%b stb=%b want %b/1", cyc, m0_err_o, s_stb_o, (cyc == 8)); end
        end
        nchk++; if (m1_err_o !== 1'b0) begin nerr++; $display("FAIL t4_m1_noerr: got %b want 0", m1_err_o); end
        tick();
        m0_stb_i = 0;
        #1;
        nchk++; if (arb_state !== 2'b10 || s_stb_o !== 1'b0 || m0_err_o !== 1'b0) begin nerr++; $display("FAIL t4_gap: got st=%b stb=%b err=%b want 10/0/0", arb_state, s_stb_o, m0_err_o); end
        tick(); tick(); #1;
        nchk++; if (arb_gnt !== 2'b10 || s_adr_o !== 32'h600) begin nerr++; $display("FAIL t4_m1_gnt: got gnt=%b adr=%h want 10/600", arb_gnt, s_adr_o); end
        cfg_tmo = '0;
        errs = 0;
        repeat (1000) begin
            tick(); #1;
            if (m1_err_o !== 1'b0) errs++;
        end
        nchk++; if (errs != 0 || arb_state !== 2'b01) begin nerr++; $display("FAIL t4_tmo0: got errs=%0d st=%b want 0/01", errs, arb_state); end
        s_ack_i = 1; s_lack_i = 1;
        tick();
        s_ack_i = 0; s_lack_i = 0; m1_stb_i = 0;
        tick();
    endtask

    task automatic test_corners();
        cfg_tmo = 16'd4;
        m0_stb_i = 1;
        tick(); tick(); tick(); tick();
        s_lack_i = 1;
        #1;
        nchk++; if (m0_err_o !== 1'b0 || m0_lack_o !== 1'b1) begin nerr++; $display("FAIL t5a_lack_wins: got err=%b lack=%b want 0/1", m0_err_o, m0_lack_o); end
        tick();
        s_lack_i = 0; m0_stb_i = 0;
        #1;
        nchk++; if (arb_state !== 2'b10) begin nerr++; $display("FAIL t5a_gap: got %b want 10", arb_state); end
        tick();
        cfg_tmo = '0;
        m0_stb_i = 1;
        tick(); #1;
        nchk++; if (s_stb_o !== 1'b1) begin nerr++; $display("FAIL t5b_busy: got %b want 1", s_stb_o); end
        m0_stb_i = 0;
        #1;
        nchk++; if (s_stb_o !== 1'b0) begin nerr++; $display("FAIL t5b_stb_follow: got %b want 0", s_stb_o); end
        tick(); #1;
        nchk++; if (arb_state !== 2'b10 || m0_err_o !== 1'b0) begin nerr++; $display("FAIL t5b_abort_gap: got st=%b err=%b want 10/0", arb_state, m0_err_o); end
        tick();
    endtask

    task automatic test_resets();
        m0_stb_i = 1;
        tick(); #1;
        nchk++; if (arb_gnt !== 2'b01) begin nerr++; $display("FAIL t6_gnt: got %b want 01", arb_gnt); end
        cfg_fsm_reset = 1;
        tick();
        cfg_fsm_reset = 0;
        #1;
        nchk++; if (arb_state !== 2'b00 || arb_gnt !== 2'b00 || s_stb_o !== 1'b0) begin nerr++; $display("FAIL t6_fsm_reset: got st=%b gnt=%b stb=%b want 00/00/0", arb_state, arb_gnt, s_stb_o); end
        tick(); #1;
        nchk++; if (arb_state !== 2'b01 || arb_gnt !== 2'b01 || s_stb_o !== 1'b1) begin nerr++; $display("FAIL t6_regrant: got st=%b gnt=%b stb=%b want 01/01/1", arb_state, arb_gnt, s_stb_o); end
        rst_n = 0;
        #1;
        nchk++; if (s_stb_o !== 1'b0 || arb_gnt !== 2'b00 || arb_state !== 2'b00) begin nerr++; $display("FAIL t6_async_rst: got stb=%b gnt=%b st=%b want 0/00/00", s_stb_o, arb_gnt, arb_state); end
        tick();
        rst_n = 1;
        #1;
        nchk++; if (arb_state !== 2'b00) begin nerr++; $display("FAIL t6_post_rst_idle: got %b want 00", arb_state); end
        tick(); #1;
        nchk++; if (arb_gnt !== 2'b01 || s_stb_o !== 1'b1) begin nerr++; $display("FAIL t6_post_rst_gnt: got gnt=%b stb=%b want 01/1", arb_gnt, s_stb_o); end
        m0_stb_i = 0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_watchdog();
        test_corners();
        test_resets();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
